// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the register file's single write port.
// Two requesters (ALU and load unit) compete for one write per cycle.
// Contention is resolved round-robin against the last granted requester.
// The winning write is registered once before it reaches the register file.
// Writes to x0 are accepted but never reach the write port.
// Cycles in which both requesters are valid and the pipeline is not held
// are counted by a saturating contention counter.
module rf_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_hold,
    input  logic                  i_alu_valid,
    input  logic [ADDR_WIDTH-1:0] i_alu_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_alu_rd_data,
    output logic                  o_alu_ready,
    input  logic                  i_lsu_valid,
    input  logic [ADDR_WIDTH-1:0] i_lsu_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_lsu_rd_data,
    output logic                  o_lsu_ready,
    output logic                  o_rf_wr_en,
    output logic [ADDR_WIDTH-1:0] o_rf_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rf_rd_data,
    output logic                  o_last_grant,
    output logic [15:0]           o_conflict_cnt
);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Increment that sticks at the top value instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] val);
        if (val == CNT_MAX) begin
            return CNT_MAX;
        end
        return val + 16'd1;
    endfunction

    logic                  alu_gnt;
    logic                  lsu_gnt;
    logic                  xfer;
    logic                  contend;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  last_grant_q, last_grant_d;
    logic                  wr_en_q,      wr_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q,    rd_addr_d;
    logic [DATA_WIDTH-1:0] rd_data_q,    rd_data_d;
    logic [15:0]           cnt_q,        cnt_d;

    // Grant decision: held or resetting pipeline grants nothing; a lone
    // requester always wins; under contention the one not granted last wins.
    always_comb begin
        alu_gnt = 1'b0;
        lsu_gnt = 1'b0;
        contend = 1'b0;
        if (!i_rst && !i_hold) begin
            if (i_alu_valid && i_lsu_valid) begin
                contend = 1'b1;
                if (last_grant_q) begin
                    alu_gnt = 1'b1;
                end else begin
                    lsu_gnt = 1'b1;
                end
            end else begin
                alu_gnt = i_alu_valid;
                lsu_gnt = i_lsu_valid;
            end
        end
    end

    assign xfer     = alu_gnt | lsu_gnt;
    assign sel_addr = lsu_gnt ? i_lsu_rd_addr : i_alu_rd_addr;
    assign sel_data = lsu_gnt ? i_lsu_rd_data : i_alu_rd_data;

    // Next-state: capture the winning write, drop x0 writes, track the
    // last winner and count contention cycles.
    always_comb begin
        last_grant_d = last_grant_q;
        wr_en_d      = 1'b0;
        rd_addr_d    = rd_addr_q;
        rd_data_d    = rd_data_q;
        cnt_d        = cnt_q;
        if (xfer) begin
            last_grant_d = lsu_gnt;
            wr_en_d      = (sel_addr != '0);
            rd_addr_d    = sel_addr;
            rd_data_d    = sel_data;
        end
        if (contend) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    // State registers; asynchronous reset discards any in-flight transfer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_grant_q <= 1'b1;
            wr_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            rd_data_q    <= '0;
            cnt_q        <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wr_en_q      <= wr_en_d;
            rd_addr_q    <= rd_addr_d;
            rd_data_q    <= rd_data_d;
            cnt_q        <= cnt_d;
        end
    end

    assign o_alu_ready    = alu_gnt;
    assign o_lsu_ready    = lsu_gnt;
    assign o_rf_wr_en     = wr_en_q;
    assign o_rf_rd_addr   = rd_addr_q;
    assign o_rf_rd_data   = rd_data_q;
    assign o_last_grant   = last_grant_q;
    assign o_conflict_cnt = cnt_q;

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning register data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, meaning register index width (32 GPRs).
REQ-003 The block SHALL have port i_clk  input  1  clock; all state rising-edge triggered.
REQ-004 The block SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port i_hold  input  1  pipeline stall; blocks all grants while high.
REQ-006 The block SHALL have ports i_alu_valid  input  1, i_alu_rd_addr  input  ADDR_WIDTH, i_alu_rd_data  input  DATA_WIDTH: ALU writeback request.
REQ-007 The block SHALL have port o_alu_ready  output  1  ALU request accepted this cycle.
REQ-008 The block SHALL have ports i_lsu_valid  input  1, i_lsu_rd_addr  input  ADDR_WIDTH, i_lsu_rd_data  input  DATA_WIDTH: load-unit writeback request.
REQ-009 The block SHALL have port o_lsu_ready  output  1  LSU request accepted this cycle.
REQ-010 The block SHALL have ports o_rf_wr_en  output  1, o_rf_rd_addr  output  ADDR_WIDTH, o_rf_rd_data  output  DATA_WIDTH: registered drive of the register file's single write port.
REQ-011 The block SHALL have port o_last_grant  output  1  arbitration pointer (0 = ALU last granted, 1 = LSU).
REQ-012 The block SHALL have port o_conflict_cnt  output  16  saturating count of cycles with both requesters valid and i_hold low.

Function
REQ-013 Handshake: a request SHALL transfer in the cycle where its valid and ready are both high; requester holds valid/addr/data stable until transfer.
REQ-014 Ready SHALL be combinational from valid, i_hold, and o_last_grant; ready SHALL never be high while its own valid is low.
REQ-015 With i_hold high, o_alu_ready and o_lsu_ready SHALL both be 0.
REQ-016 Only one valid, i_hold low: that requester SHALL be granted regardless of o_last_grant.
REQ-017 Both valid, i_hold low: the requester other than o_last_grant SHALL be granted (round-robin); at most one ready high per cycle.
REQ-018 o_last_grant SHALL update at the edge after any transfer to the identity of the granted requester; otherwise it SHALL hold.
REQ-019 Latency: a transfer in cycle N SHALL appear on o_rf_wr_en/o_rf_rd_addr/o_rf_rd_data in cycle N+1 (one register stage).
REQ-020 o_rf_wr_en SHALL be 1 for exactly one cycle per transfer whose rd_addr is nonzero; a transfer with rd_addr 0 SHALL be accepted (ready high) but produce o_rf_wr_en 0.
REQ-021 In cycles with no transfer, o_rf_wr_en SHALL be 0 and o_rf_rd_addr/o_rf_rd_data SHALL hold their previous values.
REQ-022 o_conflict_cnt SHALL increment by 1 each cycle both valids are high and i_hold is low, and SHALL saturate at 16'hFFFF without wrap.
REQ-023 Sustained contention SHALL alternate grants ALU, LSU, ALU, ... so neither requester waits more than one cycle.

Reset
REQ-024 While i_rst is high, o_rf_wr_en SHALL be 0, o_rf_rd_addr 0, o_rf_rd_data 0, o_conflict_cnt 0, o_last_grant 1 (ALU wins first contention).
REQ-025 Reset asserted mid-operation SHALL immediately clear all state; a transfer in the reset cycle SHALL be lost and no write issued after deassertion.
REQ-026 Readies SHALL be 0 while i_rst is high.

Verification
REQ-027 After reset, ALU only: valid, addr 5, data 32'hDEADBEEF -> o_alu_ready 1 same cycle; next cycle o_rf_wr_en 1, addr 5, data DEADBEEF; o_last_grant 0.
REQ-028 Both valid for 4 cycles after reset (ALU addr 1/data 1, LSU addr 2/data 2, each reasserted after transfer) -> grants ALU, LSU, ALU, LSU; o_conflict_cnt 4.
REQ-029 LSU valid, addr 0, data 32'h1234 -> o_lsu_ready 1; next cycle o_rf_wr_en 0; o_last_grant 1.
REQ-030 Both valid with i_hold 1 for 3 cycles -> both ready 0, o_rf_wr_en 0, o_conflict_cnt unchanged; on i_hold 0 round-robin winner granted.
REQ-031 Force o_conflict_cnt to 16'hFFFE via 65534 contention cycles, then 2 more -> value 16'hFFFF, stays 16'hFFFF.
REQ-032 Assert i_rst during ALU transfer cycle (addr 7) -> no o_rf_wr_en pulse after release; all outputs at reset values.
